// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: turns validated PS/2 bytes into key events.
// Handles the E0/F0/E1 prefix protocol and drops housekeeping bytes.
// Incomplete sequences are abandoned on receive error or timeout.
// Events are buffered in a first-word-fall-through FIFO with a valid/ready head.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppresses typematic repeats).
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  input  logic       code_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] err_count,
  output logic [7:0] drop_count,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pause_q, pause_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  drop_q, drop_d;

  // Decoded event candidate from the sequencer (before repeat filtering)
  logic        push;
  logic [7:0]  push_code;
  logic        push_ext;
  logic        push_brk;
  logic        evt_push;

  logic        is_hk;
  logic        is_fake_shift;
  logic        timeout_hit;

  assign is_hk = (code_byte == 8'h00) || (code_byte == 8'hAA) || (code_byte == 8'hEE) ||
                 (code_byte == 8'hFA) || (code_byte == 8'hFE) || (code_byte == 8'hFF);
  // E0 12 / E0 59 are the keyboard's fake shift codes around extended keys
  assign is_fake_shift = (code_byte == 8'h12) || (code_byte == 8'h59);
  assign timeout_hit   = (state_q != S_IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));

  // Sequencer state, pause counter, timeout counter and error counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pause_q <= 3'd0;
      to_q    <= '0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode of the scan-code protocol; a byte always beats a timeout
  always_comb begin
    state_d   = state_q;
    pause_d   = pause_q;
    to_d      = to_q;
    err_d     = err_q;
    push      = 1'b0;
    push_code = code_byte;
    push_ext  = 1'b0;
    push_brk  = 1'b0;
    if (code_valid) begin
      to_d = '0;
      if (code_err) begin
        state_d = S_IDLE;
        pause_d = 3'd0;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (code_byte == 8'hE0) begin
              state_d = S_EXT;
            end else if (code_byte == 8'hF0) begin
              state_d = S_BRK;
            end else if (code_byte == 8'hE1) begin
              state_d = S_PAUSE;
              pause_d = 3'd7;
            end else if (!is_hk) begin
              push = 1'b1;
            end
          end
          S_EXT: begin
            if (code_byte == 8'hF0) begin
              state_d = S_EXT_BRK;
            end else begin
              state_d  = S_IDLE;
              push     = !is_fake_shift;
              push_ext = 1'b1;
            end
          end
          S_BRK: begin
            state_d  = S_IDLE;
            push     = 1'b1;
            push_brk = 1'b1;
          end
          S_EXT_BRK: begin
            state_d  = S_IDLE;
            push     = !is_fake_shift;
            push_ext = 1'b1;
            push_brk = 1'b1;
          end
          S_PAUSE: begin
            // The pause sequence is a fixed 8-byte burst; content is ignored
            if (pause_q <= 3'd1) begin
              state_d   = S_IDLE;
              pause_d   = 3'd0;
              push      = 1'b1;
              push_code = 8'hE1;
            end else begin
              pause_d = pause_q - 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q == S_IDLE) begin
      to_d = '0;
    end else if (timeout_hit) begin
      state_d = S_IDLE;
      pause_d = 3'd0;
      to_d    = '0;
    end else begin
      to_d = to_q + TW'(1);
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       tm_valid_q, tm_valid_d;
  logic [7:0] tm_code_q, tm_code_d;
  logic       tm_ext_q, tm_ext_d;
  logic       tm_match;

  assign tm_match = tm_valid_q && (tm_code_q == push_code) && (tm_ext_q == push_ext);

  // Last-pressed key register used to suppress auto-repeat presses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tm_valid_q <= 1'b0;
      tm_code_q  <= 8'd0;
      tm_ext_q   <= 1'b0;
    end else begin
      tm_valid_q <= tm_valid_d;
      tm_code_q  <= tm_code_d;
      tm_ext_q   <= tm_ext_d;
    end
  end

  // Repeat filter: drop a re-press of the held key, track press/release
  always_comb begin
    tm_valid_d = tm_valid_q;
    tm_code_d  = tm_code_q;
    tm_ext_d   = tm_ext_q;
    evt_push   = push;
    if (push) begin
      if (!push_brk) begin
        if (tm_match) begin
          evt_push = 1'b0;
        end else begin
          tm_valid_d = 1'b1;
          tm_code_d  = push_code;
          tm_ext_d   = push_ext;
        end
      end else if (tm_match) begin
        tm_valid_d = 1'b0;
      end
    end
  end
`else
  assign evt_push = push;
`endif

  // Event FIFO
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fifo_full;
  logic          fifo_pop;
  logic          fifo_wr;

  assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_pop  = evt_valid && evt_ready;
  // A push into a full FIFO survives only when the head leaves in the same cycle
  assign fifo_wr   = evt_push && (!fifo_full || fifo_pop);

  // Count next-state and drop counter next-state
  always_comb begin
    cnt_d  = cnt_q + CW'(fifo_wr) - CW'(fifo_pop);
    drop_d = drop_q;
    if (evt_push && !fifo_wr && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 8'd0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      // Storage entry; cleared on reset so the empty head reads as zero
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          mem_q[gi] <= 10'd0;
        end else if (fifo_wr && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= {push_code, push_ext, push_brk};
        end
      end
    end
  endgenerate

  assign evt_valid = (cnt_q != '0);
  assign {evt_code, evt_ext, evt_break} = mem_q[rd_ptr_q];
  assign err_count  = err_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Randomized scoreboard bench for ps2_key_sequencer.
// The reference model interprets the byte stream as whole sequences.
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int T     = 40;

  logic       CLK, RST;
  logic       code_valid, code_err, evt_ready;
  logic [7:0] code_byte;
  logic       evt_valid, evt_ext, evt_break, busy;
  logic [7:0] evt_code, err_count, drop_count;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST),
    .code_valid(code_valid), .code_byte(code_byte), .code_err(code_err),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .err_count(err_count), .drop_count(drop_count), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  // Reference model state
  logic [9:0] sb [$];
  logic [7:0] seq [$];
  int         m_cnt   = 0;
  int         gap     = 0;
  int         err_exp = 0;
  int         drop_exp = 0;
  bit         pend;
  logic [9:0] pend_val;
  bit         tm_v;
  logic [7:0] tm_code;
  bit         tm_ext;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_hk(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic void emit(input logic [7:0] c, input bit x, input bit brk);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!brk) begin
      if (tm_v && tm_code == c && tm_ext == x) return;
      tm_v = 1; tm_code = c; tm_ext = x;
    end else if (tm_v && tm_code == c && tm_ext == x) begin
      tm_v = 0;
    end
`endif
    pend     = 1;
    pend_val = {c, x, brk};
  endfunction

  // Interpret the byte sequence collected so far as a whole
  function automatic void model_byte(input logic [7:0] b);
    bit brk;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        emit(8'hE1, 0, 0);
        seq.delete();
      end
    end else if (seq.size() == 1) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        seq.delete();
        if (!is_hk(b)) emit(b, 0, 0);
      end
    end else if (seq[0] == 8'hF0) begin
      emit(b, 0, 1);
      seq.delete();
    end else begin
      if (!(seq.size() == 2 && b == 8'hF0)) begin
        brk = (seq.size() == 3);
        seq.delete();
        if (b != 8'h12 && b != 8'h59) emit(b, 1, brk);
      end
    end
  endfunction

  // One clock cycle of stimulus; checks state left by the previous edge first
  task automatic step(input bit v, input logic [7:0] b, input bit e, input bit r);
    bit pop;
    chk("evt_valid", evt_valid, m_cnt > 0);
    chk("busy", busy, (seq.size() > 0) && (gap < T));
    chk("err_count", err_count, err_exp);
    chk("drop_count", drop_count, drop_exp);
    code_valid = v; code_byte = b; code_err = e; evt_ready = r;
    pend = 0;
    pop  = (m_cnt > 0) && r;
    if (v) begin
      if (gap >= T) seq.delete();
      gap = 0;
      if (e) begin
        seq.delete();
        if (err_exp < 255) err_exp++;
      end else begin
        model_byte(b);
      end
    end else begin
      gap++;
    end
    if (pend) begin
      if (m_cnt < DEPTH || pop) begin
        sb.push_back(pend_val);
        m_cnt++;
      end else if (drop_exp < 255) begin
        drop_exp++;
      end
    end
    if (pop) m_cnt--;
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 1);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(0, 8'h00, 0, r);
  endtask

  task automatic do_reset();
    RST = 1; code_valid = 0; code_byte = 0; code_err = 0; evt_ready = 0;
    sb.delete(); seq.delete();
    m_cnt = 0; gap = 0; err_exp = 0; drop_exp = 0; tm_v = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_evt_ext", evt_ext, 0);
    chk("rst_evt_break", evt_break, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_busy", busy, 0);
  endtask

  function automatic bit rnd_ready();
    return $urandom_range(0, 99) < 60;
  endfunction

  function automatic logic [7:0] pick_byte();
    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA,
                              8'h00, 8'hFA, 8'h1C, 8'h1D, 8'h75, 8'h14};
    int idx = $urandom_range(0, 15);
    if (idx < 12) return pool[idx];
    return 8'($urandom_range(0, 255));
  endfunction

  // Monitor: pops the scoreboard on every handshake, checks head stability
  bit         hold;
  logic [9:0] hold_val;
  initial begin
    logic [9:0] exp;
    hold = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", evt_valid, 1);
          chk("hold_data", {evt_code, evt_ext, evt_break}, hold_val);
        end
        if (evt_valid && evt_ready) begin
          n_pop++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL phantom_event: got %0h expected none at %0t",
                     {evt_code, evt_ext, evt_break}, $time);
          end else begin
            exp = sb.pop_front();
            chk("event", {evt_code, evt_ext, evt_break}, exp);
          end
        end
        hold     = evt_valid && !evt_ready;
        hold_val = {evt_code, evt_ext, evt_break};
      end
    end
  end

  initial begin
    int base;
    do_reset();

    // Make / break with single-cycle latency
    send(8'h1C);
    chk("latency_make", evt_valid, 1);
    send(8'hF0); send(8'h1C);
    chk("latency_break", evt_valid, 1);
    idle(3, 1);

    // Extended keys and fake shift
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    idle(2, 1);
    chk("busy_after_fake", busy, 0);

    // Pause sequence and housekeeping
    base = n_pop;
    foreach (seq[i]) ;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hAA); send(8'hFA);
    idle(4, 1);
    chk("pause_events", n_pop - base, 1);

    // Overflow with consumer stalled, then drain
    step(1, 8'h15, 0, 0); step(1, 8'h16, 0, 0); step(1, 8'h1A, 0, 0);
    step(1, 8'h1B, 0, 0); step(1, 8'h1D, 0, 0); step(1, 8'h1E, 0, 0);
    idle(3, 0);
    chk("drop_count_full", drop_count, 2);
    idle(8, 1);

    // Timeout of a dangling break prefix, then an errored byte
    send(8'hF0);
    idle(T, 1);
    send(8'h1C);
    idle(2, 1);
    step(1, 8'h1C, 1, 1);
    idle(2, 1);
    chk("err_count_one", err_count, 1);
    chk("busy_after_err", busy, 0);

    // Typematic repeats
    send(8'h15); idle(2, 1);
    base = n_pop;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(4, 1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_events", n_pop - base, 3);
`else
    chk("typematic_events", n_pop - base, 5);
`endif

    // Reset in the middle of a handshake and a sequence
    step(1, 8'h21, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'hE0, 0, 0);
    do_reset();

    // Randomized traffic
    repeat (2500) begin
      int r = $urandom_range(0, 99);
      if (r < 4) begin
        idle($urandom_range(T - 3, T + 3), rnd_ready());
      end else begin
        repeat ($urandom_range(0, 2)) step(0, 8'h00, 0, rnd_ready());
        step(1, pick_byte(), $urandom_range(0, 99) < 4, rnd_ready());
      end
    end

    idle(DEPTH + 6, 1);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
